// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with mid-bit sampler and RX FIFO.
// CPU side reads bytes and status over a small strobe/ack register bus.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 16,
  parameter int FIFO_AW      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_bit,
  input  logic [1:0] wb_addr,
  input  logic [7:0] wb_data_in,
  output logic [7:0] wb_data_out,
  input  logic       wb_we,
  input  logic       wb_stb,
  output logic       wb_ack,
  output logic       rx_avail
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [FIFO_AW:0] DEPTH = (FIFO_AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    RECOVER
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2:0]         idx;
  logic [7:0]         sh;
  logic               rxs_0;
  logic               rxs;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wp;
  logic [FIFO_AW-1:0] rp;
  logic [FIFO_AW:0]   count;
  logic               overrun;
  logic               frame_err;
  logic [7:0]         rdata;

  logic full;
  logic stop_hit;
  logic push_req;
  logic accept;
  logic pop;
  logic do_push;
  logic w1c;

  assign full     = (count == DEPTH);
  assign rx_avail = (count != '0);
  assign stop_hit = (state == STOP) && (cnt == LAST);
  assign push_req = stop_hit && rxs;
  assign accept   = wb_stb && !wb_ack;
  assign pop      = accept && !wb_we && (wb_addr == 2'd0) && rx_avail;
  assign do_push  = push_req && (!full || pop);
  assign w1c      = accept && wb_we && (wb_addr == 2'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxs_0 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      rxs_0 <= rx_bit;
      rxs   <= rxs_0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == MID) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            sh[idx] <= rxs;
            if (idx == 3'd7) state <= STOP;
            else idx <= idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= rxs ? IDLE : RECOVER;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RECOVER: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= sh;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (do_push && !pop) count <= count + 1'b1;
      else if (pop && !do_push) count <= count - 1'b1;
    end
  end

  // Clear first so a same-edge set overrides it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (w1c && wb_data_in[2]) overrun <= 1'b0;
      if (w1c && wb_data_in[3]) frame_err <= 1'b0;
      if (push_req && full && !pop) overrun <= 1'b1;
      if (stop_hit && !rxs) frame_err <= 1'b1;
    end
  end

  always_comb begin
    rdata = 8'h00;
    if (!wb_we) begin
      unique case (wb_addr)
        2'd0: rdata = rx_avail ? mem[rp] : 8'h00;
        2'd1: rdata = {4'b0, frame_err, overrun, full, rx_avail};
        2'd2: rdata = 8'(count);
        default: rdata = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_ack      <= 1'b0;
      wb_data_out <= 8'h00;
    end else begin
      wb_ack <= accept;
      if (accept) wb_data_out <= rdata;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: frames, glitch, overrun,
// frame error, push/pop collision and mid-frame reset.
module tb_uart_rx_fifo;

  logic       clk;
  logic       reset;
  logic       rx_bit;
  logic [1:0] wb_addr;
  logic [7:0] wb_data_in;
  logic [7:0] wb_data_out;
  logic       wb_we;
  logic       wb_stb;
  logic       wb_ack;
  logic       rx_avail;

  int passed = 0;
  int total = 0;

  uart_rx_fifo #(
    .CLKS_PER_BIT(8),
    .FIFO_DEPTH(4),
    .FIFO_AW(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_bit(rx_bit),
    .wb_addr(wb_addr),
    .wb_data_in(wb_data_in),
    .wb_data_out(wb_data_out),
    .wb_we(wb_we),
    .wb_stb(wb_stb),
    .wb_ack(wb_ack),
    .rx_avail(rx_avail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  // Called at a negedge; returns at the negedge just before
  // the edge that samples the stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    rx_bit = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_bit = b[i];
      repeat (8) @(negedge clk);
    end
    rx_bit = stop_v;
    repeat (6) @(negedge clk);
  endtask

  task automatic bus(input logic [1:0] a, input logic we,
                     input logic [7:0] d, output logic [7:0] q,
                     output logic ack1, output logic ack2);
    wb_addr    = a;
    wb_we      = we;
    wb_data_in = d;
    wb_stb     = 1'b1;
    @(negedge clk);
    q      = wb_data_out;
    ack1   = wb_ack;
    wb_stb = 1'b0;
    wb_we  = 1'b0;
    @(negedge clk);
    ack2 = wb_ack;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] q);
    logic k1;
    logic k2;
    bus(a, 1'b0, 8'h00, q, k1, k2);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    logic [7:0] q;
    logic k1;
    logic k2;
    bus(a, 1'b1, d, q, k1, k2);
  endtask

  initial begin
    logic [7:0] q;
    logic a1;
    logic a2;
    reset      = 1'b0;
    rx_bit     = 1'b1;
    wb_addr    = 2'd0;
    wb_data_in = 8'h00;
    wb_we      = 1'b0;
    wb_stb     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack", {7'b0, wb_ack}, 8'h00);
    chk("rst_dout", wb_data_out, 8'h00);
    chk("rst_avail", {7'b0, rx_avail}, 8'h00);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    send_frame(8'h43, 1'b1);
    chk("avail_pre", {7'b0, rx_avail}, 8'h00);
    @(negedge clk);
    chk("avail_post", {7'b0, rx_avail}, 8'h01);
    bus(2'd0, 1'b0, 8'h00, q, a1, a2);
    chk("rd_43", q, 8'h43);
    chk("ack_hi", {7'b0, a1}, 8'h01);
    chk("ack_lo", {7'b0, a2}, 8'h00);
    rd(2'd1, q);
    chk("stat_0", q, 8'h00);

    rx_bit = 1'b0;
    repeat (2) @(negedge clk);
    rx_bit = 1'b1;
    repeat (12) @(negedge clk);
    rd(2'd2, q);
    chk("glitch_cnt", q, 8'h00);
    rd(2'd1, q);
    chk("glitch_stat", q, 8'h00);

    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1);
      @(negedge clk);
    end
    rd(2'd2, q);
    chk("ovr_cnt", q, 8'h04);
    rd(2'd1, q);
    chk("ovr_stat", q, 8'h07);
    for (int i = 1; i <= 4; i++) begin
      rd(2'd0, q);
      chk("ovr_rd", q, 8'(i));
    end
    rd(2'd0, q);
    chk("empty_rd", q, 8'h00);
    rd(2'd1, q);
    chk("ovr_only", q, 8'h04);
    wr(2'd1, 8'h04);
    rd(2'd1, q);
    chk("ovr_clr", q, 8'h00);

    send_frame(8'hA5, 1'b0);
    @(negedge clk);
    repeat (20) @(negedge clk);
    rd(2'd1, q);
    chk("ferr_set", q, 8'h08);
    rd(2'd2, q);
    chk("ferr_cnt", q, 8'h00);
    wr(2'd1, 8'h08);
    repeat (20) @(negedge clk);
    rd(2'd1, q);
    chk("ferr_once", q, 8'h00);
    rx_bit = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(8'h5A, 1'b1);
    @(negedge clk);
    rd(2'd0, q);
    chk("rd_5a", q, 8'h5A);
    rd(2'd1, q);
    chk("stat_5a", q, 8'h00);

    send_frame(8'h11, 1'b1);
    @(negedge clk);
    send_frame(8'h22, 1'b1);
    @(negedge clk);
    send_frame(8'h33, 1'b1);
    bus(2'd0, 1'b0, 8'h00, q, a1, a2);
    chk("coll_rd", q, 8'h11);
    rd(2'd2, q);
    chk("coll_cnt", q, 8'h02);
    rd(2'd0, q);
    chk("coll_22", q, 8'h22);

    rx_bit = 1'b0;
    repeat (8) @(negedge clk);
    rx_bit = 1'b1;
    repeat (20) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_avail", {7'b0, rx_avail}, 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    rd(2'd2, q);
    chk("rst_cnt", q, 8'h00);
    send_frame(8'h3C, 1'b1);
    @(negedge clk);
    rd(2'd2, q);
    chk("3c_cnt", q, 8'h01);
    rd(2'd0, q);
    chk("rd_3c", q, 8'h3C);
    rd(2'd1, q);
    chk("3c_stat", q, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
